// File: rtl/mem_wb.sv
// mem_wb: pipeline register between the memory-access and write-back stages.
// Captures the register-write result and HI/LO write request from the memory
// stage.
//
// The register supports:
//   - stall hold
//   - bubble insertion
//   - flush
//
// Optional retire counter: define MEM_WB_RETIRE_CNT_EN to add the retire_cnt
// output, the cnt_clr input and the counter logic.
module mem_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_valid,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_valid
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt,
    input  logic        cnt_clr
`endif
);

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    logic mem_stall;
    logic wb_stall;
    logic do_bubble;
    logic do_load;

    // Stall bits for the earlier pipeline stages are not used in this stage.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    assign mem_stall = stall[4];
    assign wb_stall  = stall[5];

    // Action select: flush beats bubble beats hold beats load.
    // The illegal combination mem_stall=0 with wb_stall=1 is treated as a load.
    assign do_bubble = flush || (mem_stall && !wb_stall);
    assign do_load   = !flush && !mem_stall;

    // Pipeline register: reset and bubble both clear the slot; hold keeps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd    <= REG_AW'(0);
            wb_wreg  <= 1'b0;
            wb_wdata <= REG_DW'(0);
            wb_whilo <= 1'b0;
            wb_hi    <= REG_DW'(0);
            wb_lo    <= REG_DW'(0);
            wb_valid <= 1'b0;
        end else if (do_bubble) begin
            wb_wd    <= REG_AW'(0);
            wb_wreg  <= 1'b0;
            wb_wdata <= REG_DW'(0);
            wb_whilo <= 1'b0;
            wb_hi    <= REG_DW'(0);
            wb_lo    <= REG_DW'(0);
            wb_valid <= 1'b0;
        end else if (do_load) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            wb_valid <= mem_valid;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    // Retire counter: counts valid loads, clear wins, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= REG_DW'(0);
        end else if (cnt_clr) begin
            retire_cnt <= REG_DW'(0);
        end else if (do_load && mem_valid) begin
            retire_cnt <= retire_cnt + REG_DW'(1);
        end
    end
`endif

endmodule
